// File: rtl/jk_sync_counter.sv
// Synchronous modulo-N up/down counter.
// Every state bit is a JK storage cell. All state changes come from the
// J/K excitation built here; the excitation vectors are exported so each bit
// can be checked against the single-cell JK truth table.
module jk_sync_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             wrap
);

    // A modulo outside 2..2**WIDTH cannot be represented by the bank.
    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
        $error("jk_sync_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] load_target;
    logic             chain;

    assign at_top    = (Q == MAX_VAL);
    assign at_bottom = (Q == '0);
    assign Qn        = ~Q;

    // Excitation generator: load, then the two wrap cases, then plain
    // binary counting in toggle form, otherwise hold (J = K = 0).
    always_comb begin
        J           = '0;
        K           = '0;
        chain       = 1'b1;
        load_target = (d > MAX_VAL) ? MAX_VAL : d;
        if (load) begin
            J = load_target;
            K = ~load_target;
        end else if (en) begin
            if (up && at_top) begin
                J = '0;
                K = '1;
            end else if (!up && at_bottom) begin
                J = MAX_VAL;
                K = ~MAX_VAL;
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    J[i]  = chain;
                    K[i]  = chain;
                    chain = chain & (up ? Q[i] : Qn[i]);
                end
            end
        end
    end

    // Terminal count: the next enabled count step will wrap.
    always_comb begin
        tc = en & ~load & ~clr & ((up & at_top) | (~up & at_bottom));
    end

    // JK bank update with synchronous clear; wrap is the registered tc.
    always_ff @(posedge clk) begin
        if (clr) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= (J & ~Q) | (~K & Q);
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_jk_sync_counter;

    localparam int WIDTH  = 4;
    localparam int MODULO = 10;

    logic             clk;
    logic             clr;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             tc;
    logic             wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int m_q     = 0;
    bit m_wrap  = 0;
    bit m_valid = 0;

    jk_sync_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .J    (J),
        .K    (K),
        .Q    (Q),
        .Qn   (Qn),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic setInputs(input logic c, input logic e, input logic u,
                             input logic l, input logic [WIDTH-1:0] dv);
        clr  = c;
        en   = e;
        up   = u;
        load = l;
        d    = dv;
    endtask

    task automatic applyStimulus(input logic c, input logic e, input logic u,
                                 input logic l, input logic [WIDTH-1:0] dv);
        setInputs(c, e, u, l, dv);
        @(posedge clk);
        #1;
    endtask

    // Model: count value as a plain integer moving through 0..MODULO-1.
    always @(posedge clk) begin
        if (clr) begin
            m_q     = 0;
            m_wrap  = 0;
            m_valid = 1;
        end else if (load) begin
            m_q    = (int'(d) >= MODULO) ? MODULO - 1 : int'(d);
            m_wrap = 0;
        end else if (en) begin
            if (up) begin
                m_wrap = (m_q == MODULO - 1);
                m_q    = (m_q + 1) % MODULO;
            end else begin
                m_wrap = (m_q == 0);
                m_q    = (m_q + MODULO - 1) % MODULO;
            end
        end else begin
            m_wrap = 0;
        end
    end

    // Compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        int exp_j;
        int exp_k;
        int exp_tc;
        int tgt;
        int mask;
        if (m_valid) begin
            exp_tc = (en && !load && !clr &&
                      ((up && m_q == MODULO - 1) || (!up && m_q == 0))) ? 1 : 0;
            exp_j = 0;
            exp_k = 0;
            if (load) begin
                tgt   = (int'(d) >= MODULO) ? MODULO - 1 : int'(d);
                exp_j = tgt;
                exp_k = (~tgt) & ((1 << WIDTH) - 1);
            end else if (en) begin
                if (up && m_q == MODULO - 1) begin
                    exp_j = 0;
                    exp_k = (1 << WIDTH) - 1;
                end else if (!up && m_q == 0) begin
                    exp_j = MODULO - 1;
                    exp_k = (~(MODULO - 1)) & ((1 << WIDTH) - 1);
                end else begin
                    mask  = up ? (m_q ^ (m_q + 1)) : (m_q ^ (m_q - 1));
                    exp_j = mask & ((1 << WIDTH) - 1);
                    exp_k = exp_j;
                end
            end
            checkOutput("model Q",    int'(Q),    m_q);
            checkOutput("model Qn",   int'(Qn),   (~m_q) & ((1 << WIDTH) - 1));
            checkOutput("model wrap", int'(wrap), int'(m_wrap));
            checkOutput("model tc",   int'(tc),   exp_tc);
            checkOutput("model J",    int'(J),    exp_j);
            checkOutput("model K",    int'(K),    exp_k);
        end
    end

    initial begin
        setInputs(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);

        // Reset held for two edges with counting requested
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("reset Q",    int'(Q),    0);
        checkOutput("reset Qn",   int'(Qn),   15);
        checkOutput("reset wrap", int'(wrap), 0);
        checkOutput("reset tc",   int'(tc),   0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("release Q", int'(Q), 1);

        // Count up to the top and wrap
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("up Q=9",  int'(Q),  9);
        checkOutput("up tc",   int'(tc), 1);
        checkOutput("up J@9",  int'(J),  0);
        checkOutput("up K@9",  int'(K),  15);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("up wrap Q",  int'(Q),    0);
        checkOutput("up wrap",    int'(wrap), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("up wrap end", int'(wrap), 0);

        // Down wrap from 0
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("load0 Q", int'(Q), 0);
        setInputs(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        checkOutput("down tc@0", int'(tc), 1);
        checkOutput("down J@0",  int'(J),  9);
        checkOutput("down K@0",  int'(K),  6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("down Q=9",  int'(Q),    9);
        checkOutput("down wrap", int'(wrap), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("down Q=8",  int'(Q),    8);

        // Load clamp, then clear beats load
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        checkOutput("clamp Q",    int'(Q),    9);
        checkOutput("clamp wrap", int'(wrap), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        checkOutput("clr>load Q", int'(Q), 0);

        // Hold at 7, then the all-toggle step 7 -> 8
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("hold Q", int'(Q), 7);
        checkOutput("hold J", int'(J), 0);
        checkOutput("hold K", int'(K), 0);
        setInputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        #1;
        checkOutput("toggle J", int'(J), 15);
        checkOutput("toggle K", int'(K), 15);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("toggle Q", int'(Q), 8);

        // Clear in the middle of a count
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("mid Q=6", int'(Q), 6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("mid clr Q",    int'(Q),    0);
        checkOutput("mid clr wrap", int'(wrap), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("mid resume Q", int'(Q), 1);

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 80,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 8,
                          WIDTH'($urandom_range(0, 15)));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
